// File: rtl/fpu_f32_div_iter.sv
// fpu_f32_div_iter: LANES-wide IEEE-754 F32 restoring divider, one shared FSM.
// Define FPU_DIV_FLAGS_EN to add the per-lane exception FLAGS output.
module fpu_f32_div_iter #(
    parameter int LANES      = 2,
    parameter int RADIX_BITS = 1
) (
    input  logic                MCLK,
    input  logic                RST,
    input  logic                IN_VALID,
    output logic                IN_READY,
    input  logic [32*LANES-1:0] A,
    input  logic [32*LANES-1:0] B,
    output logic                OUT_VALID,
    input  logic                OUT_READY,
    output logic [32*LANES-1:0] O,
`ifdef FPU_DIV_FLAGS_EN
    output logic [5*LANES-1:0]  FLAGS,
`endif
    output logic                BUSY,
    output logic                INTR
);
    localparam int         N    = 26 / RADIX_BITS;
    localparam logic [4:0] LAST = 5'(N - 1);

    if (RADIX_BITS != 1 && RADIX_BITS != 2) begin : g_bad_radix
        $error("RADIX_BITS must be 1 or 2");
    end

    typedef enum logic [2:0] {
        S_IDLE, S_PREP, S_ITER, S_ROUND, S_DONE
    } state_t;

    state_t     r_state;
    state_t     w_next;
    logic [4:0] r_cnt;
    logic       r_out_valid;
    logic       r_intr;
    logic       w_accept;
    logic       w_load_o;

    assign IN_READY  = (r_state == S_IDLE) && !RST;
    assign BUSY      = (r_state != S_IDLE);
    assign OUT_VALID = r_out_valid;
    assign INTR      = r_intr;
    assign w_accept  = IN_VALID && IN_READY;
    assign w_load_o  = (r_state == S_DONE) && !r_out_valid;

    // One restoring step: {next partial remainder, quotient bit}
    function automatic logic [25:0] f_step(
        input logic [24:0] rem,
        input logic [23:0] dv
    );
        logic        ge;
        logic [23:0] dif;
        ge  = rem >= {1'b0, dv};
        dif = rem[23:0] - dv;
        return {ge ? dif : rem[23:0], 1'b0, ge};
    endfunction

    always_ff @(posedge MCLK or posedge RST) begin
        if (RST) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_out_valid <= 1'b0;
            r_intr      <= 1'b0;
        end else begin
            r_state <= w_next;
            r_cnt   <= (r_state == S_ITER) ? r_cnt + 5'd1 : 5'd0;
            r_intr  <= w_load_o;
            if (w_load_o)
                r_out_valid <= 1'b1;
            else if (r_out_valid && OUT_READY)
                r_out_valid <= 1'b0;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE:  if (w_accept) w_next = S_PREP;
            S_PREP:  w_next = S_ITER;
            S_ITER:  if (r_cnt == LAST) w_next = S_ROUND;
            S_ROUND: w_next = S_DONE;
            S_DONE:  if (r_out_valid && OUT_READY) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        logic [31:0]       r_a, r_b;
        logic [24:0]       r_rem;
        logic [23:0]       r_div;
        logic [25:0]       r_q;
        logic signed [9:0] r_exp;
        logic              r_sgn, r_nan, r_inf, r_zero;
        logic [31:0]       r_res, r_o;

        logic [7:0]        w_ea, w_eb;
        logic [23:0]       w_ma, w_mb;
        logic              w_za, w_zb, w_ia, w_ib, w_na, w_nb, w_lt;
        logic [24:0]       w_rem_nx;
        logic [25:0]       w_q_nx;
        logic [24:0]       w_mr;
        logic signed [9:0] w_er;
        logic              w_up, w_st, w_ovf, w_unf;
        logic [31:0]       w_res;

        assign w_ea = r_a[30:23];
        assign w_eb = r_b[30:23];
        assign w_ma = {1'b1, r_a[22:0]};
        assign w_mb = {1'b1, r_b[22:0]};
        assign w_za = (w_ea == 8'd0);
        assign w_zb = (w_eb == 8'd0);
        assign w_ia = (w_ea == 8'hFF) && (r_a[22:0] == 23'd0);
        assign w_ib = (w_eb == 8'hFF) && (r_b[22:0] == 23'd0);
        assign w_na = (w_ea == 8'hFF) && (r_a[22:0] != 23'd0);
        assign w_nb = (w_eb == 8'hFF) && (r_b[22:0] != 23'd0);
        assign w_lt = w_ma < w_mb;

        if (RADIX_BITS == 2) begin : g_r2
            logic [25:0] w_s1, w_s2;
            assign w_s1     = f_step(r_rem, r_div);
            assign w_s2     = f_step(w_s1[25:1], r_div);
            assign w_rem_nx = w_s2[25:1];
            assign w_q_nx   = {r_q[23:0], w_s1[0], w_s2[0]};
        end else begin : g_r1
            logic [25:0] w_s1;
            assign w_s1     = f_step(r_rem, r_div);
            assign w_rem_nx = w_s1[25:1];
            assign w_q_nx   = {r_q[24:0], w_s1[0]};
        end

        // r_q = 24 mantissa bits, then guard [1] and round [0]
        assign w_st  = |r_rem;
        assign w_up  = r_q[1] & (r_q[0] | w_st | r_q[2]);
        assign w_mr  = {1'b0, r_q[25:2]} + {24'd0, w_up};
        assign w_er  = r_exp + {9'd0, w_mr[24]};
        assign w_ovf = w_er >= 10'sd255;
        assign w_unf = w_er <= 10'sd0;

        always_comb begin
            w_res = {r_sgn, w_er[7:0],
                     w_mr[24] ? w_mr[23:1] : w_mr[22:0]};
            if (r_nan)       w_res = 32'h7FC0_0000;
            else if (r_inf)  w_res = {r_sgn, 8'hFF, 23'd0};
            else if (r_zero) w_res = {r_sgn, 31'd0};
            else if (w_ovf)  w_res = {r_sgn, 8'hFF, 23'd0};
            else if (w_unf)  w_res = {r_sgn, 31'd0};
        end

        always_ff @(posedge MCLK or posedge RST) begin
            if (RST) begin
                r_a    <= '0;
                r_b    <= '0;
                r_rem  <= '0;
                r_div  <= '0;
                r_q    <= '0;
                r_exp  <= '0;
                r_sgn  <= 1'b0;
                r_nan  <= 1'b0;
                r_inf  <= 1'b0;
                r_zero <= 1'b0;
                r_res  <= '0;
                r_o    <= '0;
            end else begin
                if (w_accept) begin
                    r_a <= A[32*i +: 32];
                    r_b <= B[32*i +: 32];
                end
                if (r_state == S_PREP) begin
                    r_sgn  <= r_a[31] ^ r_b[31];
                    r_nan  <= w_na | w_nb | (w_za & w_zb) | (w_ia & w_ib);
                    r_inf  <= w_ia | w_zb;
                    r_zero <= w_za | w_ib;
                    r_div  <= w_mb;
                    r_rem  <= w_lt ? {w_ma, 1'b0} : {1'b0, w_ma};
                    r_q    <= '0;
                    r_exp  <= {2'b00, w_ea} - {2'b00, w_eb}
                              + 10'd127 - {9'd0, w_lt};
                end
                if (r_state == S_ITER) begin
                    r_rem <= w_rem_nx;
                    r_q   <= w_q_nx;
                end
                if (r_state == S_ROUND) r_res <= w_res;
                if (w_load_o) r_o <= r_res;
            end
        end

        assign O[32*i +: 32] = r_o;

`ifdef FPU_DIV_FLAGS_EN
        logic       r_inv, r_dz, r_dnm;
        logic [4:0] r_flg_res, r_flg;
        logic       w_arith;

        assign w_arith = !(r_nan || r_inf || r_zero);

        always_ff @(posedge MCLK or posedge RST) begin
            if (RST) begin
                r_inv     <= 1'b0;
                r_dz      <= 1'b0;
                r_dnm     <= 1'b0;
                r_flg_res <= '0;
                r_flg     <= '0;
            end else begin
                if (r_state == S_PREP) begin
                    r_inv <= (w_za & w_zb) | (w_ia & w_ib)
                             | (w_na & !r_a[22]) | (w_nb & !r_b[22]);
                    r_dz  <= w_zb & !w_za & !w_ia & !w_na;
                    r_dnm <= (w_za & |r_a[22:0]) | (w_zb & |r_b[22:0]);
                end
                if (r_state == S_ROUND)
                    r_flg_res <= {r_inv, r_dz, w_arith & w_ovf,
                                  r_dnm | (w_arith & w_unf),
                                  w_arith & (w_ovf | w_unf | r_q[1]
                                             | r_q[0] | w_st)};
                if (w_load_o) r_flg <= r_flg_res;
            end
        end

        assign FLAGS[5*i +: 5] = r_flg;
`endif
    end
endmodule

// File: tb/tb_fpu_f32_div_iter.sv
// Bench for fpu_f32_div_iter: radix-1 and radix-2 instances, directed
// vectors plus random normals against an exact integer division model.
`timescale 1ns/1ps
module tb_fpu_f32_div_iter;
    logic        MCLK = 1'b0;
    logic        RST;
    logic        in_valid  [2];
    logic        in_ready  [2];
    logic        out_valid [2];
    logic        out_ready [2];
    logic        busy      [2];
    logic        intr      [2];
    logic [63:0] a [2];
    logic [63:0] b [2];
    logic [63:0] o [2];
`ifdef FPU_DIV_FLAGS_EN
    logic [9:0]  flags [2];
    logic [9:0]  last_flags;
`endif
    int tests_run;
    int failed;

    always #5 MCLK = ~MCLK;

    fpu_f32_div_iter #(.LANES(2), .RADIX_BITS(1)) u_dut1 (
        .MCLK(MCLK), .RST(RST),
        .IN_VALID(in_valid[0]), .IN_READY(in_ready[0]),
        .A(a[0]), .B(b[0]),
        .OUT_VALID(out_valid[0]), .OUT_READY(out_ready[0]),
        .O(o[0]),
`ifdef FPU_DIV_FLAGS_EN
        .FLAGS(flags[0]),
`endif
        .BUSY(busy[0]), .INTR(intr[0])
    );

    fpu_f32_div_iter #(.LANES(2), .RADIX_BITS(2)) u_dut2 (
        .MCLK(MCLK), .RST(RST),
        .IN_VALID(in_valid[1]), .IN_READY(in_ready[1]),
        .A(a[1]), .B(b[1]),
        .OUT_VALID(out_valid[1]), .OUT_READY(out_ready[1]),
        .O(o[1]),
`ifdef FPU_DIV_FLAGS_EN
        .FLAGS(flags[1]),
`endif
        .BUSY(busy[1]), .INTR(intr[1])
    );

    // Exact quotient by wide integer division, then round to nearest even
    function automatic logic [31:0] ref_div(input logic [31:0] x,
                                            input logic [31:0] y);
        int ex, ey, e, sh;
        longint unsigned mx, my, q, r, m, low, half;
        bit s, zx, zy, ix, iy, nx, ny, up;
        s  = x[31] ^ y[31];
        ex = int'(x[30:23]);
        ey = int'(y[30:23]);
        zx = (ex == 0);
        zy = (ey == 0);
        ix = (ex == 255) && (x[22:0] == 23'd0);
        iy = (ey == 255) && (y[22:0] == 23'd0);
        nx = (ex == 255) && (x[22:0] != 23'd0);
        ny = (ey == 255) && (y[22:0] != 23'd0);
        if (nx || ny || (zx && zy) || (ix && iy)) return 32'h7FC00000;
        if (ix || zy) return {s, 8'hFF, 23'd0};
        if (zx || iy) return {s, 31'd0};
        mx = {40'd0, 1'b1, x[22:0]};
        my = {40'd0, 1'b1, y[22:0]};
        q  = (mx << 32) / my;
        r  = (mx << 32) % my;
        if (q >= 64'h1_0000_0000) begin
            sh = 9;
            e  = ex - ey + 127;
        end else begin
            sh = 8;
            e  = ex - ey + 126;
        end
        m    = q >> sh;
        low  = q & ((64'd1 << sh) - 64'd1);
        half = 64'd1 << (sh - 1);
        up   = (low > half) || (low == half && (r != 0 || m[0]));
        m    = m + {63'd0, up};
        if (m == (64'd1 << 24)) begin
            m = m >> 1;
            e = e + 1;
        end
        if (e >= 255) return {s, 8'hFF, 23'd0};
        if (e <= 0) return {s, 31'd0};
        return {s, e[7:0], m[22:0]};
    endfunction

    function automatic logic [31:0] rnd_norm();
        logic [31:0] v;
        v[31] = 1'($urandom);
        if ($urandom_range(0, 1) == 1)
            v[30:23] = 8'($urandom_range(1, 254));
        else
            v[30:23] = 8'($urandom_range(110, 144));
        v[22:0] = 23'($urandom);
        return v;
    endfunction

    task automatic do_op(input int d, input logic [63:0] av,
                         input logic [63:0] bv, output logic [63:0] res,
                         output int lat, output int pulses, output bit ok);
        ok = 1'b1;
        lat = 0;
        pulses = 0;
        @(negedge MCLK);
        a[d] = av;
        b[d] = bv;
        out_ready[d] = 1'b1;
        in_valid[d] = 1'b1;
        for (int k = 0; k < 50 && !in_ready[d]; k++) @(negedge MCLK);
        if (!in_ready[d]) ok = 1'b0;
        @(posedge MCLK); #1;
        in_valid[d] = 1'b0;
        while (!out_valid[d] && lat < 100) begin
            @(posedge MCLK); #1;
            lat++;
            if (intr[d]) pulses++;
        end
        res = o[d];
        if (!out_valid[d]) ok = 1'b0;
`ifdef FPU_DIV_FLAGS_EN
        last_flags = flags[d];
`endif
        @(posedge MCLK); #1;
        if (intr[d]) pulses++;
        if (out_valid[d] || busy[d] || !in_ready[d]) ok = 1'b0;
    endtask

    task automatic test_reset();
        #2;
        for (int d = 0; d < 2; d++) begin
            tests_run++;
            if (in_ready[d] !== 1'b0 || out_valid[d] !== 1'b0 ||
                busy[d] !== 1'b0 || intr[d] !== 1'b0 || o[d] !== 64'd0) begin
                failed++;
                $display("FAIL reset_state d=%0d got rdy=%b vld=%b busy=%b intr=%b o=%h want 0 0 0 0 0",
                         d, in_ready[d], out_valid[d], busy[d], intr[d], o[d]);
            end
        end
        repeat (2) @(negedge MCLK);
        RST = 1'b0;
        #1;
        for (int d = 0; d < 2; d++) begin
            tests_run++;
            if (in_ready[d] !== 1'b1) begin
                failed++;
                $display("FAIL reset_release d=%0d in_ready got %b want 1",
                         d, in_ready[d]);
            end
        end
    endtask

    task automatic test_basic(input int d, input int exp_lat);
        logic [63:0] res;
        int lat, p;
        bit ok;
        do_op(d, {32'h3F800000, 32'h40C00000},
              {32'h40400000, 32'h40000000}, res, lat, p, ok);
        tests_run++;
        if (res !== {32'h3EAAAAAB, 32'h40400000}) begin
            failed++;
            $display("FAIL basic_o d=%0d got %h want 3eaaaaab40400000", d, res);
        end
        tests_run++;
        if (lat != exp_lat) begin
            failed++;
            $display("FAIL basic_latency d=%0d got %0d want %0d", d, lat, exp_lat);
        end
        tests_run++;
        if (p != 1) begin
            failed++;
            $display("FAIL basic_intr d=%0d pulses got %0d want 1", d, p);
        end
        tests_run++;
        if (!ok) begin
            failed++;
            $display("FAIL basic_handshake d=%0d got bad want clean", d);
        end
    endtask

    task automatic test_specials(input int d);
        logic [31:0] va [6] = '{32'h3F800000, 32'hBF800000, 32'h00000000,
                                32'h7F800000, 32'h7FC00001, 32'h3F800000};
        logic [31:0] vb [6] = '{32'h00000000, 32'h00000000, 32'h00000000,
                                32'h7F800000, 32'h3F800000, 32'h7F800000};
        logic [31:0] ve [6] = '{32'h7F800000, 32'hFF800000, 32'h7FC00000,
                                32'h7FC00000, 32'h7FC00000, 32'h00000000};
        logic [63:0] res;
        int lat, p;
        bit ok;
        for (int k = 0; k < 6; k++) begin
            do_op(d, {va[k], 32'h40C00000}, {vb[k], 32'h40000000},
                  res, lat, p, ok);
            tests_run++;
            if (res !== {ve[k], 32'h40400000} || !ok) begin
                failed++;
                $display("FAIL special_%0d got %h want %h%h", k, res, ve[k],
                         32'h40400000);
            end
`ifdef FPU_DIV_FLAGS_EN
            if (k == 0 || k == 2) begin
                tests_run++;
                if (last_flags !== {(k == 0) ? 5'b01000 : 5'b10000, 5'b00000}) begin
                    failed++;
                    $display("FAIL special_flags_%0d got %b want %b", k,
                             last_flags,
                             {(k == 0) ? 5'b01000 : 5'b10000, 5'b00000});
                end
            end
`endif
        end
    endtask

    task automatic test_range(input int d);
        logic [31:0] va [3] = '{32'h7F7FFFFF, 32'h00800000, 32'h00000001};
        logic [31:0] vb [3] = '{32'h3F000000, 32'h40000000, 32'h3F800000};
        logic [31:0] ve [3] = '{32'h7F800000, 32'h00000000, 32'h00000000};
        logic [63:0] res;
        int lat, p;
        bit ok;
        for (int k = 0; k < 3; k++) begin
            do_op(d, {32'h3F800000, va[k]}, {32'h40400000, vb[k]},
                  res, lat, p, ok);
            tests_run++;
            if (res !== {32'h3EAAAAAB, ve[k]} || !ok) begin
                failed++;
                $display("FAIL range_%0d got %h want 3eaaaaab%h", k, res, ve[k]);
            end
        end
    endtask

    task automatic test_backpressure(input int d);
        logic [63:0] hold;
        int lat, p, bad;
        p = 0;
        bad = 0;
        @(negedge MCLK);
        a[d] = {32'h3F800000, 32'h40C00000};
        b[d] = {32'h40400000, 32'h40000000};
        out_ready[d] = 1'b0;
        in_valid[d] = 1'b1;
        for (int k = 0; k < 50 && !in_ready[d]; k++) @(negedge MCLK);
        @(posedge MCLK); #1;
        a[d] = {32'h40C00000, 32'h3F800000};
        b[d] = {32'h40000000, 32'h40400000};
        lat = 0;
        while (!out_valid[d] && lat < 100) begin
            @(posedge MCLK); #1;
            lat++;
            if (intr[d]) p++;
        end
        tests_run++;
        if (lat != 29) begin
            failed++;
            $display("FAIL bp_latency got %0d want 29", lat);
        end
        hold = o[d];
        tests_run++;
        if (hold !== {32'h3EAAAAAB, 32'h40400000}) begin
            failed++;
            $display("FAIL bp_o got %h want 3eaaaaab40400000", hold);
        end
        repeat (10) begin
            @(posedge MCLK); #1;
            if (intr[d]) p++;
            if (o[d] !== hold || out_valid[d] !== 1'b1 ||
                busy[d] !== 1'b1 || in_ready[d] !== 1'b0) bad++;
        end
        tests_run++;
        if (bad != 0) begin
            failed++;
            $display("FAIL bp_stall_stable bad cycles got %0d want 0", bad);
        end
        tests_run++;
        if (p != 1) begin
            failed++;
            $display("FAIL bp_intr pulses got %0d want 1", p);
        end
        out_ready[d] = 1'b1;
        @(posedge MCLK); #1;
        tests_run++;
        if (out_valid[d] !== 1'b0 || busy[d] !== 1'b0 || in_ready[d] !== 1'b1) begin
            failed++;
            $display("FAIL bp_release got vld=%b busy=%b rdy=%b want 0 0 1",
                     out_valid[d], busy[d], in_ready[d]);
        end
        @(posedge MCLK); #1;
        in_valid[d] = 1'b0;
        lat = 0;
        while (!out_valid[d] && lat < 100) begin
            @(posedge MCLK); #1;
            lat++;
        end
        tests_run++;
        if (lat != 29 || o[d] !== {32'h40400000, 32'h3EAAAAAB}) begin
            failed++;
            $display("FAIL bp_held_op got lat=%0d o=%h want 29 404000003eaaaaab",
                     lat, o[d]);
        end
        @(posedge MCLK); #1;
    endtask

    task automatic test_reset_midop(input int d);
        logic [63:0] res;
        int lat, p, bad;
        bit ok;
        @(negedge MCLK);
        a[d] = {32'h40C00000, 32'h40C00000};
        b[d] = {32'h40000000, 32'h40000000};
        in_valid[d] = 1'b1;
        for (int k = 0; k < 50 && !in_ready[d]; k++) @(negedge MCLK);
        @(posedge MCLK); #1;
        in_valid[d] = 1'b0;
        repeat (5) @(posedge MCLK);
        #2;
        tests_run++;
        if (busy[d] !== 1'b1) begin
            failed++;
            $display("FAIL midop_busy got %b want 1", busy[d]);
        end
        RST = 1'b1;
        #1;
        tests_run++;
        if (out_valid[d] !== 1'b0 || busy[d] !== 1'b0 ||
            in_ready[d] !== 1'b0 || o[d] !== 64'd0) begin
            failed++;
            $display("FAIL midop_reset got vld=%b busy=%b rdy=%b o=%h want 0 0 0 0",
                     out_valid[d], busy[d], in_ready[d], o[d]);
        end
        @(negedge MCLK);
        RST = 1'b0;
        bad = 0;
        repeat (40) begin
            @(posedge MCLK); #1;
            if (out_valid[d] || busy[d]) bad++;
        end
        tests_run++;
        if (bad != 0) begin
            failed++;
            $display("FAIL midop_discard got %0d active cycles want 0", bad);
        end
        do_op(d, {32'h40C00000, 32'h40C00000}, {32'h40000000, 32'h40000000},
              res, lat, p, ok);
        tests_run++;
        if (res !== {32'h40400000, 32'h40400000} || lat != 29 || !ok) begin
            failed++;
            $display("FAIL midop_after got o=%h lat=%0d want 4040000040400000 29",
                     res, lat);
        end
    endtask

    task automatic test_random(input int d, input int nops);
        logic [31:0] x0, x1, y0, y1, e0, e1;
        logic [63:0] res;
        int lat, p;
        bit ok;
        for (int n = 0; n < nops; n++) begin
            x0 = rnd_norm();
            x1 = rnd_norm();
            y0 = rnd_norm();
            y1 = rnd_norm();
            e0 = ref_div(x0, y0);
            e1 = ref_div(x1, y1);
            do_op(d, {x1, x0}, {y1, y0}, res, lat, p, ok);
            tests_run++;
            if (res[31:0] !== e0 || !ok) begin
                failed++;
                $display("FAIL rand_d%0d_l0 %h/%h got %h want %h",
                         d, x0, y0, res[31:0], e0);
            end
            tests_run++;
            if (res[63:32] !== e1) begin
                failed++;
                $display("FAIL rand_d%0d_l1 %h/%h got %h want %h",
                         d, x1, y1, res[63:32], e1);
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        tests_run = 0;
        failed = 0;
        RST = 1'b1;
        in_valid  = '{1'b0, 1'b0};
        out_ready = '{1'b1, 1'b1};
        a = '{64'd0, 64'd0};
        b = '{64'd0, 64'd0};
        test_reset();
        test_basic(0, 29);
        test_basic(1, 16);
        test_specials(0);
        test_range(0);
        test_backpressure(0);
        test_reset_midop(0);
        test_random(1, 500);
        test_random(0, 100);
        $display("[TB] %0d tests run, %0d failed", tests_run, failed);
        $finish;
    end
endmodule

// File: doc/fpu_f32_div_iter.md
Name: fpu_f32_div_iter

Overview:
Parametrised multi-lane IEEE-754 single-precision iterative divider for the Meitner FPU subsystem. It is the next-generation FPU divide path, with these additions:
- LANES independent F32 lanes
- selectable quotient bits per cycle
- valid/ready handshakes on input and output
- BUSY status and a completion interrupt

All lanes share one control FSM, so every lane executes the same operation at the same time.

Parameters:
LANES, 2, number of parallel F32 lanes (1..8).
RADIX_BITS, 1, quotient bits retired per iteration cycle; only 1 or 2 are legal, any other value is an elaboration error.

Ports:
MCLK  input  1  system clock, all state on rising edge.
RST  input  1  asynchronous active-high reset.
IN_VALID  input  1  operand set valid.
IN_READY  output  1  block can accept operands.
A  input  32*LANES  dividends, lane i = A[32*i+31:32*i].
B  input  32*LANES  divisors, same packing.
OUT_VALID  output  1  quotients valid.
OUT_READY  input  1  consumer accepts quotients.
O  output  32*LANES  quotients, same packing.
BUSY  output  1  an operation is in flight or a result is not yet consumed.
INTR  output  1  completion pulse.

Behaviour:
- Reset (asynchronous, takes effect immediately):
  - FSM goes to IDLE.
  - OUT_VALID=0, O=0, BUSY=0, INTR=0.
  - IN_READY=0 while RST is high and 1 after release.
  - Any in-flight operation is discarded with no output.
- FSM states: IDLE -> PREP -> ITER -> ROUND -> DONE -> IDLE.
  - IN_READY=1 only in IDLE.
  - BUSY = (state != IDLE).
- IDLE: on IN_VALID & IN_READY, latch A and B, then go to PREP.
- PREP (1 cycle), per lane:
  - Unpack sign, exponent and mantissa; denormal inputs are treated as signed zero.
  - Classify specials.
  - If ma < mb, shift ma left by 1 and decrement the exponent.
  - Exponent = ea - eb + 127, held as a 10-bit signed value.
- ITER: N = 26/RADIX_BITS cycles of restoring division.
  - Produces 24 mantissa bits plus guard and round bits.
  - A nonzero final remainder sets sticky.
- ROUND (1 cycle):
  - Round to nearest even; a mantissa carry increments the exponent.
  - Exponent >= 255 gives ±inf.
  - Exponent <= 0 gives ±0 (flush to zero, no denormal outputs).
  - Special-case results override the arithmetic result.
- DONE:
  - OUT_VALID=1 and O is registered; both stay stable until OUT_VALID & OUT_READY.
  - On that handshake, go to IDLE; IN_READY rises the next cycle.
  - New operands are never accepted in the same cycle as the output handshake.
- Latency: OUT_VALID rises exactly N+3 cycles after the accepting edge (29 for RADIX_BITS=1, 16 for RADIX_BITS=2).
- INTR: exactly one-cycle pulse in the first cycle OUT_VALID is high; it does not repeat while stalled.
- Sign: sa^sb for every result except NaN.
- Special cases, per lane:
  - Either operand NaN -> 0x7FC00000 (canonical qNaN).
  - 0/0 or inf/inf -> 0x7FC00000.
  - Finite nonzero / 0 -> ±inf.
  - inf / finite -> ±inf.
  - Finite / inf -> ±0.
  - 0 / nonzero finite -> ±0.
- Lanes are fully independent in data; a special case in one lane does not affect the others.

Optional Feature:
FPU_DIV_FLAGS_EN:
- Defined: adds output port FLAGS [5*LANES].
  - Per lane, bit order is [4] invalid, [3] divide-by-zero, [2] overflow, [1] underflow (including FTZ of a nonzero result and denormal inputs), [0] inexact.
  - FLAGS is registered with O, valid under OUT_VALID, and reset to 0.
- Undefined: the port and its logic are absent; data behaviour is identical.

Test Plan:
1. LANES=2, RADIX_BITS=1, A={0x3F800000,0x40C00000}, B={0x40400000,0x40000000} -> O={0x3EAAAAAB,0x40400000}; OUT_VALID 29 cycles after accept; INTR single pulse.
2. Specials, one per run:
   - 0x3F800000/0 -> 0x7F800000
   - 0xBF800000/0 -> 0xFF800000
   - 0/0 -> 0x7FC00000
   - 0x7F800000/0x7F800000 -> 0x7FC00000
   - 0x7FC00001/0x3F800000 -> 0x7FC00000
   - 0x3F800000/0x7F800000 -> 0x00000000
   - With FLAGS: 1/0 gives 5'b01000 and 0/0 gives 5'b10000.
3. Range:
   - 0x7F7FFFFF/0x3F000000 -> 0x7F800000 (overflow)
   - 0x00800000/0x40000000 -> 0x00000000 (FTZ)
   - 0x00000001/0x3F800000 -> 0x00000000
4. Backpressure: OUT_READY low for 10 cycles -> O and OUT_VALID stable, BUSY=1, IN_READY=0, one INTR pulse; handshake -> BUSY=0 and IN_READY=1 on the next cycle; IN_VALID held during DONE is not accepted until then.
5. Reset mid-op: assert RST during the 5th ITER cycle -> OUT_VALID=0 and BUSY=0 immediately; after release, a 6.0/2.0 divide returns 0x40400000 with normal latency.
6. RADIX_BITS=2 with scenario 1 vectors -> identical O; OUT_VALID 16 cycles after accept; 1000 random normal operand pairs match the reference model bit-exactly.
